uart_tx_serializer: RTL

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// 8-bit UART transmitter: start, 8 data bits LSB first, optional even parity, 1-2 stop bits.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data and stop bits.
module uart_tx_serializer #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int STOP_BITS = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_send,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(STOP_CLKS + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state  <= IDLE;
            o_tx   <= 1'b1;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_send) begin
                        shift  <= i_data;
                        cnt    <= '0;
                        idx    <= '0;
                        o_tx   <= 1'b0;
                        o_busy <= 1'b1;
                        state  <= START;
                    end else begin
                        o_tx   <= 1'b1;
                        o_busy <= 1'b0;
                    end
                end
                START: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        o_tx  <= shift[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        // idx wraps 7 -> 0 on the way out of DATA
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            o_tx  <= ^shift;
                            state <= PARITY;
`else
                            o_tx  <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            o_tx <= shift[idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        o_tx  <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == STOP_LAST) begin
                        cnt    <= '0;
                        o_done <= 1'b1;
                        // A pending request chains straight into the next start bit
                        if (i_send) begin
                            shift <= i_data;
                            idx   <= '0;
                            o_tx  <= 1'b0;
                            state <= START;
                        end else begin
                            o_tx   <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt    <= '0;
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
